// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int         MDU_ITERS      = 32;
  localparam logic [4:0] MDU_LAST_COUNT = 5'(MDU_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the 64-bit accumulator: shift-add for multiply, restoring
// shift-subtract for divide (remainder in the upper half, quotient in the lower).
module mdu_step (
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] partial;
  logic [31:0] diff;

  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    partial  = {acc[63:32], acc[31]};
    // The true difference is below the divisor whenever it is taken, so 32 bits suffice.
    diff     = partial[31:0] - operand;
    acc_next = {sum, acc[31:1]};
    if (is_div) begin
      if (partial >= {1'b0, operand}) begin
        acc_next = {diff, acc[30:0], 1'b1};
      end else begin
        acc_next = {partial[31:0], acc[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: IDLE/RUN/FIX FSM around mdu_step.
// Optional MDU_FAST_MULT_EN gives MULT/MULTU a single-cycle product path.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import mdu_pkg::*;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [63:0] acc, acc_step;
  logic [1:0]  op_q;
  logic [31:0] a_q, mag_b;
  logic        b_sign_q;

  logic        start_div, start_signed, fast_path;
  logic [31:0] a_abs, b_abs;
  logic        run_div, run_signed, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] quot, rem, hi_fix, lo_fix;

  assign start_div    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign start_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_abs        = abs32(inA, start_signed);
  assign b_abs        = abs32(inB, start_signed);

  always_comb begin
`ifdef MDU_FAST_MULT_EN
    fast_path = ~start_div;
`else
    fast_path = 1'b0;
`endif
  end

  mdu_step u_step (
    .acc      (acc),
    .operand  (mag_b),
    .is_div   (run_div),
    .acc_next (acc_step)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = fast_path ? FIX : RUN;
      RUN:     if (count == MDU_LAST_COUNT) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction from magnitudes; divide-by-zero overrides the iterated result.
  always_comb begin
    run_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    run_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    a_neg      = run_signed & a_q[31];
    b_neg      = run_signed & b_sign_q;
    prod       = (a_neg ^ b_neg) ? (~acc + 64'd1) : acc;
    quot       = (a_neg ^ b_neg) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem        = a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
    hi_fix     = prod[63:32];
    lo_fix     = prod[31:0];
    if (run_div) begin
      if (mag_b == 32'd0) begin
        hi_fix = a_q;
        lo_fix = 32'hFFFF_FFFF;
      end else begin
        hi_fix = rem;
        lo_fix = quot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 5'd0;
      acc      <= 64'd0;
      op_q     <= MDU_MULT;
      a_q      <= 32'd0;
      mag_b    <= 32'd0;
      b_sign_q <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            a_q      <= inA;
            mag_b    <= b_abs;
            b_sign_q <= inB[31];
            count    <= 5'd0;
`ifdef MDU_FAST_MULT_EN
            acc      <= fast_path ? ({32'd0, a_abs} * {32'd0, b_abs}) : {32'd0, a_abs};
`else
            acc      <= {32'd0, a_abs};
`endif
          end else begin
            if (mthi) hi <= inA;
            if (mtlo) lo <= inA;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 5'd1;
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency queued at launch, checked at completion.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] inA = 32'd0;
  logic [31:0] inB = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic [31:0] prev_hi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int latencyOf(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
    return o[1] ? 33 : 1;
`else
    return (o == 2'b11 || o != 2'b11) ? 33 : 33;
`endif
  endfunction

  // Reference model using wide native arithmetic (no corner-case overflow at 64 bits).
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sbv, sp, sq, sr;
    logic [63:0] ua, ub, up, uq, ur;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    eh  = 32'd0;
    el  = 32'd0;
    case (o)
      MDU_MULT: begin
        sp = sa * sbv;
        eh = sp[63:32];
        el = sp[31:0];
      end
      MDU_MULTU: begin
        up = ua * ub;
        eh = up[63:32];
        el = up[31:0];
      end
      MDU_DIV: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sbv;
          sr = sa % sbv;
          eh = sr[31:0];
          el = sq[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          eh = ur[31:0];
          el = uq[31:0];
        end
      end
    endcase
  endfunction

  task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                               input logic with_move);
    exp_t e;
    @(negedge clk);
    e.name    = name;
    e.hi      = eh;
    e.lo      = el;
    e.lat     = latencyOf(o);
    e.prev_hi = hi;
    sb.push_back(e);
    op    = o;
    inA   = a;
    inB   = b;
    start = 1'b1;
    mthi  = with_move;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    inA   = $urandom;
    inB   = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  task automatic collectResult(input logic disturb);
    exp_t e;
    int   cycles;
    cycles = 0;
    e = sb.pop_front();
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (cycles == 10) checkOutput({e.name, "_hold"}, hi, e.prev_hi);
      if (disturb && cycles == 5) begin
        start = 1'b1;
        mthi  = 1'b1;
        op    = MDU_MULTU;
        inA   = 32'hDEAD_BEEF;
      end else if (cycles == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mthi  = 1'b0;
    checkOutput({e.name, "_lat"}, 32'(cycles), 32'(e.lat));
    checkOutput({e.name, "_hi"}, hi, e.hi);
    checkOutput({e.name, "_lo"}, lo, e.lo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, eh, el;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    reset = 1'b0;

    @(negedge clk);
    inA  = 32'hDEAD_BEEF;
    mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi_hi", hi, 32'hDEAD_BEEF);
    checkOutput("mthi_lo", lo, 32'd0);

    inA  = 32'hCAFE_F00D;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    checkOutput("mtboth_hi", hi, 32'hCAFE_F00D);
    checkOutput("mtboth_lo", lo, 32'hCAFE_F00D);

    applyStimulus("start_vs_mthi", MDU_DIVU, 32'd3, 32'd4, 32'd3, 32'd0, 1'b1);
    collectResult(1'b0);

    applyStimulus("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    collectResult(1'b0);
    applyStimulus("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    collectResult(1'b0);
    applyStimulus("div_neg_a", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    collectResult(1'b0);
    applyStimulus("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    collectResult(1'b0);
    applyStimulus("div_by_zero", MDU_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    collectResult(1'b0);
    applyStimulus("div_overflow", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    collectResult(1'b0);
    applyStimulus("div_neg_b_disturbed", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    collectResult(1'b1);

    // Abort a DIVU with reset sampled at E10.
    @(negedge clk);
    op    = MDU_DIVU;
    inA   = 32'd100;
    inB   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("abort_late_hi", hi, 32'd0);
    checkOutput("abort_late_lo", lo, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      if (i == 5) rb = ~rb + 32'd1;
      model(ro, ra, rb, eh, el);
      applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, eh, el, 1'b0);
      collectResult(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
